rtc_bus_scheduler: RTL and testbench

Transaction scheduler for the RTC parallel bus. It shares the single bus between two requesters: user register writes from the configuration logic, and a periodic refresh sweep that reads the time/date registers. It sequences the write FSM and the read FSM through their `inicio`/`end_flag` handshakes, captures read results, and publishes a coherent time snapshot. It sits between the user/config logic and the two bus FSMs (write and read).

---
 rtl/rtc_pkg.sv | 33 +++
 rtl/rtc_tick_counter.sv | 37 +++
 rtl/rtc_bus_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// ============================================================================
// Module   : rtc_pkg
// Purpose  : Shared widths, RTC register map constants and scheduler states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rtc_pkg;

   localparam int c_data_w = 8;
   localparam int c_addr_w = 8;

   // Time/date register block; offsets are relative to c_rd_base
   localparam logic [c_addr_w-1:0] c_rd_base   = 8'h21;
   localparam int                  c_off_sec   = 0;
   localparam int                  c_off_min   = 1;
   localparam int                  c_off_hour  = 2;
   localparam int                  c_off_day   = 3;
   localparam int                  c_off_month = 4;
   localparam int                  c_off_year  = 5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_START = 3'd1,
      ST_WR_WAIT  = 3'd2,
      ST_RD_START = 3'd3,
      ST_RD_WAIT  = 3'd4,
      ST_RD_NEXT  = 3'd5
   } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/rtc_tick_counter.sv
// ============================================================================
// Module   : rtc_tick_counter
// Purpose  : Wrap counter 0..MAX-1 with clear and a terminal-count pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_tick_counter #(
   parameter int MAX = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int               c_w    = (MAX > 1) ? $clog2(MAX) : 1;
   localparam logic [c_w-1:0]   c_last = c_w'(MAX - 1);

   logic [c_w-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= (r_count == c_last) ? '0 : r_count + c_w'(1);
      end
   end

   assign o_tc = i_en && !i_clr && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/rtc_bus_scheduler.sv
// ============================================================================
// Module   : rtc_bus_scheduler
// Purpose  : Arbitrates the RTC bus between user writes and periodic sweeps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_scheduler
   import rtc_pkg::*;
#(
   parameter int                  N_READ        = 6,
   parameter logic [c_addr_w-1:0] RD_BASE       = c_rd_base,
   parameter int                  REFRESH_TICKS = 1000,
   parameter int                  TIMEOUT       = 512
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_req,
   input  logic [c_addr_w-1:0]   wr_addr,
   input  logic [c_data_w-1:0]   wr_data,
   output logic                  wr_ack,
   output logic                  esc_inicio,
   input  logic                  esc_end_flag,
   output logic                  lec_inicio,
   input  logic                  lec_end_flag,
   input  logic [c_data_w-1:0]   lec_data,
   output logic [c_addr_w-1:0]   bus_addr,
   output logic [c_data_w-1:0]   bus_wdata,
   output logic [8*N_READ-1:0]   time_out,
   output logic                  sweep_done,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int                 c_idx_w    = (N_READ > 1) ? $clog2(N_READ) : 1;
   localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_READ - 1);

   sched_state_e         r_state, w_state_nxt;
   logic [c_idx_w-1:0]   r_idx, w_idx_nxt;
   logic                 r_sweep_active, w_sweep_active_nxt;
   logic                 r_timeout_err, w_timeout_err_nxt;
   logic                 r_refresh_pending;
   logic                 r_wr_ack, r_esc_inicio, r_lec_inicio, r_sweep_done, r_busy;
   logic [c_addr_w-1:0]  r_bus_addr;
   logic [c_data_w-1:0]  r_bus_wdata;
   logic [c_data_w-1:0]  r_shadow [N_READ];
   logic [c_data_w-1:0]  r_time   [N_READ];
   logic                 w_latch_wr, w_sweep_start, w_rd_capture, w_sweep_commit, w_wr_done;
   logic                 w_refresh_tc, w_to_tc, w_in_start, w_in_wait;

   assign w_in_start = (r_state == ST_WR_START) || (r_state == ST_RD_START);
   assign w_in_wait  = (r_state == ST_WR_WAIT)  || (r_state == ST_RD_WAIT);

   rtc_tick_counter #(.MAX(REFRESH_TICKS)) u_refresh_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (1'b0),
      .i_en  (1'b1),
      .o_tc  (w_refresh_tc)
   );

   // Cleared in the START state so the count is zero on the first WAIT cycle
   rtc_tick_counter #(.MAX(TIMEOUT)) u_timeout_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_in_start),
      .i_en  (w_in_wait),
      .o_tc  (w_to_tc)
   );

   always_comb begin
      w_state_nxt        = r_state;
      w_idx_nxt          = r_idx;
      w_sweep_active_nxt = r_sweep_active;
      w_timeout_err_nxt  = r_timeout_err;
      w_latch_wr         = 1'b0;
      w_sweep_start      = 1'b0;
      w_rd_capture       = 1'b0;
      w_sweep_commit     = 1'b0;
      w_wr_done          = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (wr_req) begin
               w_latch_wr  = 1'b1;
               w_state_nxt = ST_WR_START;
            end else if (r_refresh_pending) begin
               w_sweep_start      = 1'b1;
               w_sweep_active_nxt = 1'b1;
               w_idx_nxt          = '0;
               w_state_nxt        = ST_RD_START;
            end
         end
         ST_WR_START: w_state_nxt = ST_WR_WAIT;
         ST_WR_WAIT: begin
            if (esc_end_flag) begin
               w_wr_done         = 1'b1;
               w_timeout_err_nxt = 1'b0;
               w_state_nxt       = r_sweep_active ? ST_RD_NEXT : ST_IDLE;
            end else if (w_to_tc) begin
               w_timeout_err_nxt  = 1'b1;
               w_sweep_active_nxt = 1'b0;
               w_state_nxt        = ST_IDLE;
            end
         end
         ST_RD_START: w_state_nxt = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (lec_end_flag) begin
               w_rd_capture      = 1'b1;
               w_timeout_err_nxt = 1'b0;
               w_state_nxt       = ST_RD_NEXT;
            end else if (w_to_tc) begin
               w_timeout_err_nxt  = 1'b1;
               w_sweep_active_nxt = 1'b0;
               w_state_nxt        = ST_IDLE;
            end
         end
         ST_RD_NEXT: begin
            if (r_idx == c_idx_last) begin
               w_sweep_commit     = 1'b1;
               w_sweep_active_nxt = 1'b0;
               w_state_nxt        = ST_IDLE;
            end else if (wr_req) begin
               w_latch_wr  = 1'b1;
               w_state_nxt = ST_WR_START;
            end else begin
               w_idx_nxt   = r_idx + c_idx_w'(1);
               w_state_nxt = ST_RD_START;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state           <= ST_IDLE;
         r_idx             <= '0;
         r_sweep_active    <= 1'b0;
         r_timeout_err     <= 1'b0;
         r_refresh_pending <= 1'b0;
         r_wr_ack          <= 1'b0;
         r_esc_inicio      <= 1'b0;
         r_lec_inicio      <= 1'b0;
         r_sweep_done      <= 1'b0;
         r_busy            <= 1'b0;
         r_bus_addr        <= '0;
         r_bus_wdata       <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_idx          <= w_idx_nxt;
         r_sweep_active <= w_sweep_active_nxt;
         r_timeout_err  <= w_timeout_err_nxt;
         r_wr_ack       <= w_wr_done;
         r_esc_inicio   <= (w_state_nxt == ST_WR_START);
         r_lec_inicio   <= (w_state_nxt == ST_RD_START);
         r_sweep_done   <= w_sweep_commit;
         r_busy         <= (w_state_nxt != ST_IDLE);
         // A wrap during a pending or running sweep is absorbed
         if (w_sweep_start) begin
            r_refresh_pending <= 1'b0;
         end else if (w_refresh_tc && !r_sweep_active) begin
            r_refresh_pending <= 1'b1;
         end
         if (w_latch_wr) begin
            r_bus_addr  <= wr_addr;
            r_bus_wdata <= wr_data;
         end else if (w_state_nxt inside {ST_RD_START, ST_RD_NEXT}) begin
            r_bus_addr  <= RD_BASE + c_addr_w'(w_idx_nxt);
         end
      end
   end

   for (genvar g = 0; g < N_READ; g++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_shadow[g] <= '0;
            r_time[g]   <= '0;
         end else begin
            if (w_rd_capture && (r_idx == c_idx_w'(g))) begin
               r_shadow[g] <= lec_data;
            end
            if (w_sweep_commit) begin
               r_time[g] <= r_shadow[g];
            end
         end
      end
      assign time_out[8*g +: 8] = r_time[g];
   end

   assign wr_ack      = r_wr_ack;
   assign esc_inicio  = r_esc_inicio;
   assign lec_inicio  = r_lec_inicio;
   assign sweep_done  = r_sweep_done;
   assign busy        = r_busy;
   assign timeout_err = r_timeout_err;
   assign bus_addr    = r_bus_addr;
   assign bus_wdata   = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_scheduler.sv
// ============================================================================
// Module   : tb_rtc_bus_scheduler
// Purpose  : Directed self-checking bench with simple read/write FSM models.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rtc_bus_scheduler;

   localparam int c_n_read   = 6;
   localparam int c_refresh  = 50;
   localparam int c_timeout  = 16;
   localparam int c_rd_delay = 2;
   localparam int c_wr_delay = 3;
   localparam int c_bound    = 300;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  wr_req = 1'b0;
   logic [7:0]            wr_addr = '0;
   logic [7:0]            wr_data = '0;
   logic                  wr_ack, esc_inicio, lec_inicio, sweep_done, busy, timeout_err;
   logic                  esc_end_flag, lec_end_flag;
   logic [7:0]            lec_data;
   logic [7:0]            bus_addr, bus_wdata;
   logic [8*c_n_read-1:0] time_out;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          wr_end_cyc = 0;
   int          wr_ack_cnt = 0;
   int          rd_fail_idx = -1;
   logic [7:0]  rd_val_base = 8'h10;
   logic [7:0]  rd_idx;
   logic        wr_silent = 1'b0;
   logic [15:0] ev_q [$];
   int          ev_cyc [$];
   int          s1, target;

   rtc_bus_scheduler #(
      .N_READ        (c_n_read),
      .RD_BASE       (8'h21),
      .REFRESH_TICKS (c_refresh),
      .TIMEOUT       (c_timeout)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .esc_inicio   (esc_inicio),
      .esc_end_flag (esc_end_flag),
      .lec_inicio   (lec_inicio),
      .lec_end_flag (lec_end_flag),
      .lec_data     (lec_data),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .time_out     (time_out),
      .sweep_done   (sweep_done),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Read FSM model: answers 8'h10+idx (or rd_val_base+idx) after c_rd_delay cycles
   initial begin
      lec_end_flag = 1'b0;
      lec_data     = '0;
      forever begin
         @(negedge clk);
         lec_end_flag = 1'b0;
         if (lec_inicio) begin
            rd_idx = bus_addr - 8'h21;
            if (int'(rd_idx) != rd_fail_idx) begin
               repeat (c_rd_delay - 1) @(negedge clk);
               lec_end_flag = 1'b1;
               lec_data     = rd_val_base + rd_idx;
            end
         end
      end
   end

   initial begin
      esc_end_flag = 1'b0;
      forever begin
         @(negedge clk);
         esc_end_flag = 1'b0;
         if (esc_inicio && !wr_silent) begin
            repeat (c_wr_delay - 1) @(negedge clk);
            esc_end_flag = 1'b1;
            wr_end_cyc   = cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (lec_inicio) begin
         ev_q.push_back({8'h52, bus_addr});
         ev_cyc.push_back(cyc);
      end
      if (esc_inicio) begin
         ev_q.push_back({8'h57, bus_addr});
         ev_cyc.push_back(cyc);
      end
      if (wr_ack) wr_ack_cnt = wr_ack_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_sweep(input string tag);
      int n = 0;
      while (sweep_done !== 1'b1 && n < c_bound) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 64'(n < c_bound), 64'd1);
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      while (wr_ack !== 1'b1 && n < c_bound) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 64'(n < c_bound), 64'd1);
   endtask

   task automatic wait_rd(input logic [7:0] addr, input string tag);
      int n = 0;
      while (!(lec_inicio === 1'b1 && bus_addr === addr) && n < c_bound) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 64'(n < c_bound), 64'd1);
   endtask

   task automatic check_sweep_log(input string tag, input int first);
      for (int i = 0; i < c_n_read; i++) begin
         check_eq($sformatf("%s_rd%0d", tag, i), 64'(ev_q[first + i]), 64'({8'h52, 8'(8'h21 + i)}));
      end
   endtask

   initial begin
      // Reset state
      step(3);
      check_eq("rst_ctrl", 64'({wr_ack, esc_inicio, lec_inicio, sweep_done, busy, timeout_err}), 64'd0);
      check_eq("rst_bus", 64'({bus_addr, bus_wdata}), 64'd0);
      check_eq("rst_time", 64'(time_out), 64'd0);
      reset = 1'b1;

      // Idle refresh sweep
      wait_sweep("t1_wait");
      check_eq("t1_time", 64'(time_out), 64'h151413121110);
      check_eq("t1_nev", 64'(ev_q.size()), 64'd6);
      check_sweep_log("t1", 0);
      s1 = ev_cyc[0];
      step(1);
      check_eq("t1_done_pulse", 64'(sweep_done), 64'd0);
      check_eq("t1_idle", 64'(busy), 64'd0);

      // Single write
      ev_q.delete();
      ev_cyc.delete();
      wr_ack_cnt = 0;
      wr_addr = 8'h22;
      wr_data = 8'h45;
      wr_req  = 1'b1;
      step(1);
      check_eq("t2_esc", 64'(esc_inicio), 64'd1);
      check_eq("t2_busy", 64'(busy), 64'd1);
      check_eq("t2_addr", 64'(bus_addr), 64'h22);
      check_eq("t2_wdata", 64'(bus_wdata), 64'h45);
      wait_ack("t2_ack_wait");
      wr_req = 1'b0;
      check_eq("t2_ack_lat", 64'(cyc - wr_end_cyc), 64'd1);
      step(1);
      check_eq("t2_ack_pulse", 64'(wr_ack), 64'd0);
      step(2);
      check_eq("t2_ack_cnt", 64'(wr_ack_cnt), 64'd1);
      check_eq("t2_nev", 64'(ev_q.size()), 64'd1);

      // Preemption at sweep index 2
      ev_q.delete();
      ev_cyc.delete();
      wait_rd(8'h23, "t3_wait_rd2");
      wr_addr = 8'h30;
      wr_data = 8'h5A;
      wr_req  = 1'b1;
      wait_ack("t3_ack_wait");
      wr_req = 1'b0;
      wait_sweep("t3_sweep");
      check_eq("t3_nev", 64'(ev_q.size()), 64'd7);
      check_eq("t3_ev0", 64'(ev_q[0]), 64'h5221);
      check_eq("t3_ev2", 64'(ev_q[2]), 64'h5223);
      check_eq("t3_ev3", 64'(ev_q[3]), 64'h5730);
      check_eq("t3_ev4", 64'(ev_q[4]), 64'h5224);
      check_eq("t3_ev6", 64'(ev_q[6]), 64'h5226);
      check_eq("t3_time", 64'(time_out), 64'h151413121110);

      // Write request in the same cycle as the refresh wrap
      target = s1 - 2 + c_refresh;
      while (target <= cyc + 2) target += c_refresh;
      ev_q.delete();
      ev_cyc.delete();
      begin
         int n = 0;
         while (cyc != target && n < c_bound) begin
            @(negedge clk);
            n++;
         end
      end
      check_eq("t4_sync", 64'(cyc), 64'(target));
      wr_addr = 8'h24;
      wr_data = 8'h77;
      wr_req  = 1'b1;
      wait_ack("t4_ack_wait");
      wr_req = 1'b0;
      wait_sweep("t4_sweep");
      check_eq("t4_nev", 64'(ev_q.size()), 64'd7);
      check_eq("t4_first_wr", 64'(ev_q[0]), 64'h5724);
      check_eq("t4_wr_cyc", 64'(ev_cyc[0]), 64'(target + 1));
      check_sweep_log("t4", 1);
      check_eq("t4_time", 64'(time_out), 64'h151413121110);

      // Read FSM stalls on index 2
      rd_fail_idx = 2;
      rd_val_base = 8'hA0;
      wait_rd(8'h23, "t5_wait_rd2");
      step(c_timeout);
      check_eq("t5_err_early", 64'(timeout_err), 64'd0);
      step(1);
      check_eq("t5_err_set", 64'(timeout_err), 64'd1);
      check_eq("t5_idle", 64'(busy), 64'd0);
      check_eq("t5_time_kept", 64'(time_out), 64'h151413121110);
      rd_fail_idx = -1;
      rd_val_base = 8'h40;
      wait_sweep("t5_recover");
      check_eq("t5_err_clr", 64'(timeout_err), 64'd0);
      check_eq("t5_time_new", 64'(time_out), 64'h454443424140);

      // Reset while waiting on the write FSM
      step(1);
      wr_silent  = 1'b1;
      wr_ack_cnt = 0;
      wr_addr = 8'h25;
      wr_data = 8'h99;
      wr_req  = 1'b1;
      step(1);
      check_eq("t6_esc", 64'(esc_inicio), 64'd1);
      step(4);
      check_eq("t6_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check_eq("t6_rst_ctrl", 64'({wr_ack, esc_inicio, lec_inicio, sweep_done, busy, timeout_err}), 64'd0);
      check_eq("t6_rst_bus", 64'({bus_addr, bus_wdata}), 64'd0);
      check_eq("t6_rst_time", 64'(time_out), 64'd0);
      wr_req = 1'b0;
      step(2);
      reset = 1'b1;
      step(8);
      check_eq("t6_no_ack", 64'(wr_ack_cnt), 64'd0);
      check_eq("t6_idle", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
